// File: rtl/avion_cpu_v2.sv
// avion_cpu_v2: multi-cycle accumulator CPU on a synchronous single-port RAM.
// Optional MUL instruction (opcode 4) enabled by defining AVION_CPU_MUL_EN.
module avion_cpu_v2 #(
  parameter int ADDRESS_WIDTH = 6,
  parameter int DATA_WIDTH    = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic                     mem_we,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  input  logic [DATA_WIDTH-1:0]    mem_rdata,
  output logic [ADDRESS_WIDTH-1:0] pc,
  output logic [DATA_WIDTH-1:0]    acc,
  output logic                     carry,
  output logic                     halted
);

  localparam logic [3:0] OP_LOD = 4'd0;
  localparam logic [3:0] OP_STO = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd3;
  localparam logic [3:0] OP_MUL = 4'd4;
  localparam logic [3:0] OP_AND = 4'd5;
  localparam logic [3:0] OP_JMP = 4'd6;
  localparam logic [3:0] OP_JMZ = 4'd7;
  localparam logic [3:0] OP_NOP = 4'd8;
  localparam logic [3:0] OP_HLT = 4'd9;
  localparam logic [3:0] OP_OR  = 4'd10;
  localparam logic [3:0] OP_XOR = 4'd11;
  localparam logic [3:0] OP_NOT = 4'd12;
  localparam logic [3:0] OP_SHL = 4'd13;
  localparam logic [3:0] OP_SHR = 4'd14;
  localparam logic [3:0] OP_JMN = 4'd15;

  typedef enum logic [2:0] {
    S_FETCH,
    S_LOAD_IR,
    S_DECODE,
    S_EXEC,
    S_HALT
  } state_t;

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   ir_q, ir_d;
  logic [ADDRESS_WIDTH-1:0] pc_d;
  logic [DATA_WIDTH-1:0]   acc_d;
  logic                    carry_d;
  logic [3:0]              opcode;
  logic [ADDRESS_WIDTH-1:0] operand;

  assign opcode  = ir_q[ADDRESS_WIDTH+3:ADDRESS_WIDTH];
  assign operand = ir_q[ADDRESS_WIDTH-1:0];
  assign halted  = (state_q == S_HALT);

  function automatic logic is_mem_op(input logic [3:0] op);
    logic r;
    r = (op == OP_LOD) || (op == OP_STO) || (op == OP_ADD) || (op == OP_SUB) ||
        (op == OP_AND) || (op == OP_OR)  || (op == OP_XOR);
`ifdef AVION_CPU_MUL_EN
    r = r || (op == OP_MUL);
`endif
    return r;
  endfunction

  // Returns {carry_out, sum}.
  function automatic logic [DATA_WIDTH:0] add_c(input logic [DATA_WIDTH-1:0] a,
                                                input logic [DATA_WIDTH-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  // Returns {borrow, difference}; borrow is the unsigned b > a condition.
  function automatic logic [DATA_WIDTH:0] sub_b(input logic [DATA_WIDTH-1:0] a,
                                                input logic [DATA_WIDTH-1:0] b);
    logic [DATA_WIDTH-1:0] d;
    d = a - b;
    return {(b > a), d};
  endfunction

`ifdef AVION_CPU_MUL_EN
  // Returns {overflow, low product}; overflow flags any non-zero upper half.
  function automatic logic [DATA_WIDTH:0] mul_o(input logic [DATA_WIDTH-1:0] a,
                                                input logic [DATA_WIDTH-1:0] b);
    logic [2*DATA_WIDTH-1:0] p;
    p = {{DATA_WIDTH{1'b0}}, a} * {{DATA_WIDTH{1'b0}}, b};
    return {(|p[2*DATA_WIDTH-1:DATA_WIDTH]), p[DATA_WIDTH-1:0]};
  endfunction
`endif

  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    pc_d     = pc;
    acc_d    = acc;
    carry_d  = carry;
    mem_addr = '0;
    mem_we   = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_addr = pc;
        state_d  = S_LOAD_IR;
      end
      S_LOAD_IR: begin
        mem_addr = pc;
        ir_d     = mem_rdata;
        pc_d     = pc + 1'b1;
        state_d  = S_DECODE;
      end
      S_DECODE: begin
        state_d = S_FETCH;
        if (is_mem_op(opcode)) begin
          // Present the operand address now so the RAM data lands in EXEC.
          mem_addr = operand;
          state_d  = S_EXEC;
        end else begin
          case (opcode)
            OP_JMP: pc_d = operand;
            OP_JMZ: if (acc == '0) pc_d = operand;
            OP_JMN: if (acc[DATA_WIDTH-1]) pc_d = operand;
            OP_HLT: state_d = S_HALT;
            OP_NOT: acc_d = ~acc;
            OP_SHL: {carry_d, acc_d} = {acc, 1'b0};
            OP_SHR: {acc_d, carry_d} = {1'b0, acc};
            default: ;
          endcase
        end
      end
      S_EXEC: begin
        mem_addr = operand;
        state_d  = S_FETCH;
        case (opcode)
          OP_LOD: acc_d = mem_rdata;
          OP_STO: mem_we = 1'b1;
          OP_ADD: {carry_d, acc_d} = add_c(acc, mem_rdata);
          OP_SUB: {carry_d, acc_d} = sub_b(acc, mem_rdata);
`ifdef AVION_CPU_MUL_EN
          OP_MUL: {carry_d, acc_d} = mul_o(acc, mem_rdata);
`endif
          OP_AND: acc_d = acc & mem_rdata;
          OP_OR:  acc_d = acc | mem_rdata;
          OP_XOR: acc_d = acc ^ mem_rdata;
          default: ;
        endcase
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
    // Reset masks the bus immediately so an in-flight store never reaches memory.
    if (rst) begin
      mem_addr = '0;
      mem_we   = 1'b0;
    end
  end

  assign mem_wdata = mem_we ? acc : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      pc      <= '0;
      ir_q    <= '0;
      acc     <= '0;
      carry   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc      <= pc_d;
      ir_q    <= ir_d;
      acc     <= acc_d;
      carry   <= carry_d;
    end
  end

endmodule

// File: doc/avion_cpu_v2.md
AVION_CPU_V2 -- requirements
Module: avion_cpu_v2

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 6: width of memory address, PC and instruction operand field.
REQ-002 Parameter DATA_WIDTH, default 10: width of memory word, ACC and instruction.
REQ-003 Parameter constraint: DATA_WIDTH - ADDRESS_WIDTH SHALL be at least 4; opcode = IR[DATA_WIDTH-1:ADDRESS_WIDTH], interpreted as its low 4 bits zero-extended.
REQ-004 clk  input  1  rising-edge clock; all state changes on the rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 mem_addr  output  ADDRESS_WIDTH  memory address, combinational from state/PC/IR.
REQ-007 mem_we  output  1  memory write enable, combinational, one-cycle pulse.
REQ-008 mem_wdata  output  DATA_WIDTH  write data, equals ACC when mem_we=1, else 0.
REQ-009 mem_rdata  input  DATA_WIDTH  read data from synchronous RAM, valid one cycle after mem_addr is presented.
REQ-010 pc  output  ADDRESS_WIDTH  registered program counter.
REQ-011 acc  output  DATA_WIDTH  registered accumulator.
REQ-012 carry  output  1  registered carry/borrow flag.
REQ-013 halted  output  1  high while in HALT state.

Function
REQ-014 States: FETCH (mem_addr=pc) -> LOAD_IR (IR<=mem_rdata, pc<=pc+1) -> DECODE -> EXEC -> FETCH; HALT terminal.
REQ-015 pc increment SHALL wrap modulo 2^ADDRESS_WIDTH.
REQ-016 DECODE, memory-operand opcodes (0-5, 10, 11): mem_addr=operand, next EXEC.
REQ-017 DECODE, opcode 6 JMP: pc<=operand, next FETCH.
REQ-018 DECODE, opcode 7 JMZ: pc<=operand if acc==0, next FETCH.
REQ-019 DECODE, opcode 15 JMN: pc<=operand if acc[DATA_WIDTH-1]==1, next FETCH.
REQ-020 DECODE, opcode 8 NOP: next FETCH.
REQ-021 DECODE, opcode 9 HLT: next HALT.
REQ-022 DECODE, opcodes 12 NOT, 13 SHL, 14 SHR: act on acc in DECODE, next FETCH; NOT: acc<=~acc; SHL: {carry,acc}<={acc,0}; SHR: {acc,carry}<={0,acc}.
REQ-023 EXEC, LOD(0): acc<=mem_rdata; STO(1): mem_addr=operand, mem_we=1, mem_wdata=acc.
REQ-024 EXEC, ADD(2): {carry,acc}<=acc+mem_rdata, DATA_WIDTH+1-bit sum.
REQ-025 EXEC, SUB(3): acc<=acc-mem_rdata mod 2^DATA_WIDTH; carry<=1 iff mem_rdata>acc (unsigned borrow).
REQ-026 EXEC, AND(5)/OR(10)/XOR(11): bitwise with mem_rdata; carry unchanged.
REQ-027 EXEC always returns to FETCH.
REQ-028 Instructions take 4 cycles with memory operand, 3 cycles otherwise.
REQ-029 carry SHALL change only on ADD, SUB, SHL, SHR (and MUL per REQ-036).
REQ-030 HALT: all registers hold, mem_we=0, mem_addr=0; left only by rst.
REQ-031 mem_we SHALL be 0 in every state except EXEC of STO.

Reset
REQ-032 While rst=1: mem_we=0, mem_addr=0, mem_wdata=0 combinationally, regardless of state.
REQ-033 On a rising edge with rst=1: state<=FETCH, pc<=0, IR<=0, acc<=0, carry<=0, so halted=0.
REQ-034 rst during any state, including STO EXEC or HALT, SHALL abort the instruction with no memory write; fetch from address 0 on the first edge after release.

Configuration
REQ-035 Macro AVION_CPU_MUL_EN selects MUL support.
REQ-036 Defined: opcode 4 MUL is a memory-operand instruction, acc<=low DATA_WIDTH bits of acc*mem_rdata, carry<=1 iff the upper DATA_WIDTH product bits are non-zero.
REQ-037 Undefined: opcode 4 decodes as NOP (3 cycles, no memory access, no register change); no multiplier is synthesised.

Verification
REQ-038 mem[0..3]=LOD 50, ADD 51, STO 52, HLT; mem[50]=5, mem[51]=10 -> mem[52]=15; halted rises on the 15th rising edge after rst release; pc=4.
REQ-039 Same program with MUL 51 at mem[1] -> mem[52]=50 with AVION_CPU_MUL_EN; mem[52]=5 without it.
REQ-040 Countdown loop (LOD 51, SUB 49, JMZ 10, accumulate mem[50] into mem[48], increment mem[49], JMP 0; mem[50]=5, mem[51]=10) -> mem[52]=50, halted=1.
REQ-041 acc=1023 (default widths), ADD of a word holding 1 -> acc=0, carry=1, following JMZ taken. SUB 1 from 0 -> acc=1023, carry=1, following JMN taken.
REQ-042 acc=0b1000000001: SHL -> acc=0b0000000010, carry=1. SHR -> acc=0b0000000001, carry=0. NOT -> acc=0b1111111110.
REQ-043 Assert rst for one cycle during STO EXEC -> target word unchanged, mem_we never high; after release, fetch from 0; pc and acc reach their reset-start values.
